// File: rtl/running_total_count_p.sv
// rtl/running_total_count_p.sv - button-driven running total with press counter and 7-segment displays
//
// Purpose: each high-to-low transition of the asynchronous add_n button adds
// (mode=0) or subtracts (mode=1) the SW operand to/from a running total and
// bumps a press counter. Totals, counts and SW are shown on active-low
// 7-segment digits.
//
// Optional feature macro: RUNNING_TOTAL_SATURATE_EN
//   undefined (default): sum wraps modulo 2^SUM_W
//   defined            : sum clamps at 2^SUM_W-1 / 0
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   SW       in   IN_W operand switches (unsigned)
//   add_n    in   add button, active-low, asynchronous
//   mode     in   0 = add, 1 = subtract
//   IN_HEX   out  7*IN_DIG segments for SW (combinational)
//   CNT_HEX  out  7*CNT_DIG segments for count_q
//   SUM_HEX  out  7*SUM_DIG segments for sum_q
//   sum_q    out  SUM_W running total
//   count_q  out  CNT_W accepted press count
//   ovf      out  sticky carry/borrow flag

module running_total_count_p #(
  parameter  int IN_W    = 8,
  parameter  int SUM_W   = 16,
  parameter  int CNT_W   = 8,
  localparam int IN_DIG  = (IN_W + 3) / 4,
  localparam int SUM_DIG = (SUM_W + 3) / 4,
  localparam int CNT_DIG = (CNT_W + 3) / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      SW,
  input  logic                 add_n,
  input  logic                 mode,
  output logic [7*IN_DIG-1:0]  IN_HEX,
  output logic [7*CNT_DIG-1:0] CNT_HEX,
  output logic [7*SUM_DIG-1:0] SUM_HEX,
  output logic [SUM_W-1:0]     sum_q,
  output logic [CNT_W-1:0]     count_q,
  output logic                 ovf
);

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Button synchronizer plus history flop
  logic s1, s2, s3;
  // v1/v2 mark when s1/s2 hold real samples of add_n rather than reset values;
  // armed requires a genuine "released" sample so a button held through reset
  // is ignored until it is let go and pressed again.
  logic v1, v2, armed;
  logic press;

  assign press = s3 & ~s2 & armed;

  logic [SUM_W-1:0] sw_ext;
  logic [SUM_W:0]   raw;
  logic [SUM_W-1:0] sum_next;
  logic             flow;

  always_comb begin
    sw_ext = '0;
    sw_ext[IN_W-1:0] = SW;
    if (mode) raw = {1'b0, sum_q} - {1'b0, sw_ext};
    else      raw = {1'b0, sum_q} + {1'b0, sw_ext};
    // MSB is carry-out on add and borrow on subtract
    flow = raw[SUM_W];
`ifdef RUNNING_TOTAL_SATURATE_EN
    if (flow) sum_next = mode ? '0 : '1;
    else      sum_next = raw[SUM_W-1:0];
`else
    sum_next = raw[SUM_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      s3      <= 1'b1;
      v1      <= 1'b0;
      v2      <= 1'b0;
      armed   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf     <= 1'b0;
    end else begin
      s1    <= add_n;
      s2    <= s1;
      s3    <= s2;
      v1    <= 1'b1;
      v2    <= v1;
      armed <= armed | (v2 & s2);
      if (press) begin
        sum_q   <= sum_next;
        count_q <= count_q + CNT_W'(1);
        ovf     <= ovf | flow;
      end
    end
  end

  // Zero-padded copies so the top digit of a non-multiple-of-4 width reads cleanly
  logic [4*IN_DIG-1:0]  sw_pad;
  logic [4*SUM_DIG-1:0] sum_pad;
  logic [4*CNT_DIG-1:0] cnt_pad;

  always_comb begin
    sw_pad  = '0;
    sum_pad = '0;
    cnt_pad = '0;
    sw_pad[IN_W-1:0]   = SW;
    sum_pad[SUM_W-1:0] = sum_q;
    cnt_pad[CNT_W-1:0] = count_q;
  end

  for (genvar k = 0; k < IN_DIG; k++) begin : g_in_hex
    assign IN_HEX[7*k +: 7] = hex7(sw_pad[4*k +: 4]);
  end
  for (genvar k = 0; k < SUM_DIG; k++) begin : g_sum_hex
    assign SUM_HEX[7*k +: 7] = hex7(sum_pad[4*k +: 4]);
  end
  for (genvar k = 0; k < CNT_DIG; k++) begin : g_cnt_hex
    assign CNT_HEX[7*k +: 7] = hex7(cnt_pad[4*k +: 4]);
  end

endmodule

// File: doc/running_total_count_p.md
RUNNING_TOTAL_COUNT_P -- requirements
Module: running_total_count_p

Interface
REQ-001 SHALL have parameter IN_W, default 8, operand width in bits (1..16).
REQ-002 SHALL have parameter SUM_W, default 16, running-total width in bits (IN_W..32).
REQ-003 SHALL have parameter CNT_W, default 8, press-count width in bits (1..16).
REQ-004 SHALL derive IN_DIG=ceil(IN_W/4), SUM_DIG=ceil(SUM_W/4), CNT_DIG=ceil(CNT_W/4) as localparams.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port SW  input  IN_W  operand switches, unsigned.
REQ-008 SHALL have port add_n  input  1  add button, active-low, asynchronous to clk.
REQ-009 SHALL have port mode  input  1  0 = add operand, 1 = subtract operand.
REQ-010 SHALL have port IN_HEX  output  7*IN_DIG  SW display, digit k at [7k+:7].
REQ-011 SHALL have port CNT_HEX  output  7*CNT_DIG  count display.
REQ-012 SHALL have port SUM_HEX  output  7*SUM_DIG  running-total display.
REQ-013 SHALL have port sum_q  output  SUM_W  running-total register.
REQ-014 SHALL have port count_q  output  CNT_W  accepted-press counter register.
REQ-015 SHALL have port ovf  output  1  sticky overflow/underflow flag.

Function
REQ-016 SHALL pass add_n through a 2-flop synchronizer (s1, s2) plus a history flop s3; press = s3 & ~s2.
REQ-017 SHALL count exactly one press per high-to-low add_n transition, regardless of hold length.
REQ-018 SHALL, with add_n low first sampled at edge N, update sum_q/count_q at edge N+2; no other latency permitted.
REQ-019 SHALL sample SW and mode at the update edge; zero-extend SW to SUM_W.
REQ-020 SHALL compute sum_q +/- SW modulo 2^SUM_W when SATURATE_EN undefined.
REQ-021 SHALL increment count_q by 1 per press, wrapping 2^CNT_W-1 -> 0 in all configurations.
REQ-022 SHALL set ovf on carry-out (add) or borrow (subtract) of the sum; ovf stays 1 until reset.
REQ-023 SHALL decode each nibble combinationally to active-low segments {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110, standard DE-board glyphs for the rest.
REQ-024 SHALL zero-pad the top digit when a width is not a multiple of 4.
REQ-025 SHALL drive IN_HEX combinationally from SW (no register), valid within 1 ns of SW change in simulation.
REQ-026 SHALL drive CNT_HEX/SUM_HEX from count_q/sum_q only, stable between update edges.

Reset
REQ-027 SHALL on rst=1 at a rising edge clear sum_q, count_q, ovf to 0 and set s1, s2, s3 to 1.
REQ-028 SHALL give rst priority over a press detected in the same cycle; that press is discarded.
REQ-029 SHALL not register a press for a button held low across reset release until it is released and pressed again.

Configuration
REQ-030 SHALL, when macro RUNNING_TOTAL_SATURATE_EN is defined, clamp sum at 2^SUM_W-1 on add overflow and at 0 on subtract underflow, setting ovf on each clamp.
REQ-031 SHALL, when RUNNING_TOTAL_SATURATE_EN is undefined, wrap the sum per REQ-020 with no clamp logic present.

Verification
REQ-032 SHALL verify: defaults, reset, SW=0x01, three one-cycle presses -> sum_q=0x0003, count_q=0x03, SUM_HEX digit0=0110000.
REQ-033 SHALL verify: SW=0xAA, add_n held low 5 cycles -> count_q increments by exactly 1, sum_q increments by 0xAA, update at edge N+2.
REQ-034 SHALL verify: SW=0x80, 512 presses, wrap build -> sum_q=0x0000, count_q=0x00, ovf=1; saturate build -> sum_q=0xFFFF, ovf=1.
REQ-035 SHALL verify: sum_q=0x0005, mode=1, SW=0x07, one press -> wrap build sum_q=0xFFFE, ovf=1; saturate build sum_q=0x0000, ovf=1.
REQ-036 SHALL verify: press detected in same cycle as rst=1 -> sum_q=0, count_q=0, ovf=0; button held through reset release -> no increment until re-press.
REQ-037 SHALL verify: IN_W=12, SUM_W=20, CNT_W=4, SW=0xFFF, 17 presses -> count_q=0x1, sum_q=0x10FEF, IN_HEX all digits=0001110.
